// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_pkg
//  Purpose  : Shared BCD constants and counter-width helper for the
//             timer_digit_scan block.
//  Revision : 1.0  initial release
// ============================================================================
package timer_pkg;

  localparam int           BCD_W    = 4;
  localparam logic [3:0]   BCD_MAX  = 4'd9;
  localparam logic [3:0]   BCD_ZERO = 4'd0;

  // Bits needed to hold 0..modulus-1; never less than one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_decade_cell.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_decade_cell
//  Purpose  : One BCD decade register with synchronous clear, increment /
//             decrement qualifiers and a ripple carry/borrow in and out.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_decade_cell
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             cin_i,
  output logic [BCD_W-1:0] val_q_o,
  output logic [BCD_W-1:0] val_d_o,
  output logic             cout_o
);

  logic [BCD_W-1:0] val_q;
  logic [BCD_W-1:0] val_d;

  // Next decade value and carry/borrow; out-of-range values fold back to 0..9.
  always_comb begin
    val_d  = val_q;
    cout_o = 1'b0;
    if (clr_i) begin
      val_d = BCD_ZERO;
    end else if (cin_i && inc_i) begin
      if (val_q >= BCD_MAX) begin
        val_d  = BCD_ZERO;
        cout_o = 1'b1;
      end else begin
        val_d = val_q + 4'd1;
      end
    end else if (cin_i && dec_i) begin
      if (val_q == BCD_ZERO) begin
        val_d  = BCD_MAX;
        cout_o = 1'b1;
      end else if (val_q > BCD_MAX) begin
        val_d = BCD_MAX;
      end else begin
        val_d = val_q - 4'd1;
      end
    end
  end

  // Decade storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= BCD_ZERO;
    else     val_q <= val_d;
  end

  assign val_q_o = val_q;
  assign val_d_o = val_d;

endmodule
`default_nettype wire

// File: rtl/timer_digit_scan.sv
`default_nettype none
// ============================================================================
//  Module   : timer_digit_scan
//  Purpose  : NUM_DIGITS-decade BCD up/down counter advanced by a prescaler,
//             time-multiplexed onto one shared BCD-to-7-segment decoder.
//  Options  : TIMER_LEADING_ZERO_BLANK_EN - blank leading zero decades.
//  Revision : 1.0  initial release
// ============================================================================
module timer_digit_scan
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int SCAN_DIV   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        clear,
  input  logic                        up,
  output logic [BCD_W-1:0]            bcd_out,
  output logic                        digit_en,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic [BCD_W*NUM_DIGITS-1:0] count_value,
  output logic                        wrap
);

  localparam int                PRESC_W    = cnt_width(PRESCALE);
  localparam int                SCAN_W     = cnt_width(SCAN_DIV);
  localparam int                IDX_W      = cnt_width(NUM_DIGITS);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]            presc_q, presc_d;
  logic [SCAN_W-1:0]             scan_q, scan_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [BCD_W*NUM_DIGITS-1:0]   count_q, count_d;
  logic                          tick, inc, dec, top_cout;
  logic                          wrap_q;
  logic [BCD_W-1:0]              bcd_q, bcd_d;
  logic                          en_q, en_d;
  logic [NUM_DIGITS-1:0]         sel_q, sel_d;

  assign tick = run && (presc_q == PRESC_LAST);
  assign inc  = tick && up;
  assign dec  = tick && !up;

  // Prescaler: advances only while running, clear forces it back to zero.
  always_comb begin
    presc_d = presc_q;
    if (clear)      presc_d = '0;
    else if (tick)  presc_d = '0;
    else if (run)   presc_d = presc_q + PRESC_W'(1);
  end

  // Decade chain: each cell steps when every lower decade carries/borrows.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    logic cin;
    logic cout;
    if (i == 0) begin : g_lsd
      assign cin = 1'b1;
    end else begin : g_upper
      assign cin = g_dec[i-1].cout;
    end
    bcd_decade_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clear),
      .inc_i   (inc),
      .dec_i   (dec),
      .cin_i   (cin),
      .val_q_o (count_q[i*BCD_W +: BCD_W]),
      .val_d_o (count_d[i*BCD_W +: BCD_W]),
      .cout_o  (cout)
    );
  end

  assign top_cout = g_dec[NUM_DIGITS-1].cout;

  // Scan timing: free-running slot counter stepping the digit index.
  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Display word for the current index, taken from the next count so the
  // nibble changes in the same cycle as count_value.
  always_comb begin
`ifdef TIMER_LEADING_ZERO_BLANK_EN
    logic higher_nz;
    higher_nz = 1'b0;
`endif
    bcd_d = BCD_ZERO;
    sel_d = '0;
    en_d  = 1'b1;
`ifdef TIMER_LEADING_ZERO_BLANK_EN
    en_d  = 1'b0;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef TIMER_LEADING_ZERO_BLANK_EN
      higher_nz = higher_nz || (count_d[i*BCD_W +: BCD_W] != BCD_ZERO);
`endif
      if (idx_q == IDX_W'(i)) begin
        bcd_d    = count_d[i*BCD_W +: BCD_W];
        sel_d[i] = 1'b1;
`ifdef TIMER_LEADING_ZERO_BLANK_EN
        en_d     = higher_nz || (i == 0);
`endif
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      bcd_q   <= BCD_ZERO;
      en_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      wrap_q  <= top_cout;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_en    = en_q;
  assign digit_sel   = sel_q;
  assign count_value = count_q;
  assign wrap        = wrap_q;

endmodule
`default_nettype wire
